mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit with internal HI/LO registers, replacing the per-stage vendor divider IPs and combinational multiplier in the execute stage. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time over a valid/ready handshake. Computes division with a WIDTH-iteration restoring core. Exposes HI/LO continuously for MFHI/MFLO, and supports mid-operation flush when writeback signals an exception.

## Interface
- WIDTH, 32: operand, HI and LO width; must be even and ≥ 8.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  operation code, from mdu_pkg: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 accepted as no-op, with no write and no done.
- req_src1  in  WIDTH  rs value or dividend; MTHI/MTLO write data.
- req_src2  in  WIDTH  rt value or divisor.
- flush  in  1  abort in-flight or same-cycle request.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse, in the cycle after HI and/or LO were updated.
- hi_rdata  out  WIDTH  current HI register.
- lo_rdata  out  WIDTH  current LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **Accept:** accepted on an edge where req_valid && req_ready && !flush. Operands latch on that edge.
- **MTHI/MTLO:** written on the accept edge. FSM stays in IDLE.
- **MULT/MULTU:**
  - Signed or unsigned 2·WIDTH product; HI = upper half, LO = lower half.
  - IDLE→MUL on accept; MUL→IDLE on completion, writing HI/LO.
- **DIV/DIVU:**
  - Restoring divide on magnitudes (signed ops take two's-complement absolute values).
  - IDLE→DIV on accept. DIV runs exactly WIDTH iterations using a log2(WIDTH)+1-bit counter.
  - DIV→FIX when the counter reaches WIDTH.
  - FIX→IDLE: apply signs and write HI/LO.
    - Quotient is negated when sign(src1) ≠ sign(src2) (DIV only).
    - Remainder takes sign(src1).
    - LO = quotient, HI = remainder.
- **Divide by zero:** no trap; completes with normal latency.
  - HI = src1.
  - LO = all-ones for DIVU, or for DIV with src1 ≥ 0.
  - LO = 1 for DIV with src1 < 0.
- **DIV most-negative ÷ −1:** LO = 1 followed by WIDTH−1 zeros (0x8000_0000 at WIDTH=32), HI = 0.
- **flush:**
  - In any state, the next edge returns the FSM to IDLE, with no HI/LO write and no done.
  - A flush in the same cycle as the FIX/MUL write wins.
  - A flush in the same cycle as req_valid blocks acceptance.
  - HI/LO keep their prior values.
- **done:** registered, set on any HI/LO write edge, cleared on the next edge.
- **Reset:**
  - HI = LO = 0, state = IDLE, done = 0, busy = 0, req_ready = 1.
  - Reset mid-operation discards the operation.

## Timing
- Accept edge is the end of cycle 0.
- **MTHI/MTLO:** new value visible and done = 1 in cycle 1.
- **Multiply (default):** one cycle in MUL; HI/LO written at the end of cycle 1; done in cycle 2.
- **Divide:** DIV cycles 1..WIDTH, FIX cycle WIDTH+1, done in cycle WIDTH+2 (34 at WIDTH=32).
- **Back-to-back:** the FSM is in IDLE during the done cycle, so req_ready = 1 and a new request may be accepted in the done cycle.
- **Reads:** hi_rdata/lo_rdata change only on write edges.
- **Stall interface:** the execute stage holds while busy || (accept cycle of a mul/div).

## Configuration
- MDU_ITER_MUL_EN:
  - Defined: MULT/MULTU use a radix-2 shift-add iteration over magnitudes with a final sign fix. MUL lasts WIDTH cycles, then FIX; done in cycle WIDTH+2, matching divide latency. No WIDTH×WIDTH multiplier is instantiated.
  - Undefined: single-cycle combinational (WIDTH+1)-bit signed multiply in MUL; done in cycle 2.

## Structure
- **mdu_pkg:** op-code localparams, state enum, DIV_CYCLES = WIDTH, and latency constants used by the bench.
- **mdu_div_core:** one sub-module holding the restoring divider's partial remainder, quotient shift register and iteration counter. The iterative multiplier, when enabled, reuses its shift register and counter. The top level holds the FSM, sign handling, HI/LO, flush and done.

## Test plan
- **MULT:** src1=0xFFFF_FFFE (−2), src2=3 → done in cycle 2 (default build), HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; MULTU on the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- **DIV / DIVU:** DIV src1=−7, src2=2 → done in cycle 34, LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1); DIVU src1=7, src2=2 → LO=3, HI=1.
- **Divide corner cases:** DIV 0x8000_0000 ÷ 0xFFFF_FFFF → LO=0x8000_0000, HI=0; DIVU 5 ÷ 0 → HI=5, LO=0xFFFF_FFFF.
- **Flush:** flush at cycle 10 of DIV 100÷7 with prior HI=LO=0x1234 → IDLE next cycle, no done, HI/LO unchanged; flush with req_valid in IDLE → no accept.
- **Back-to-back:** MTHI 0xA5A5_A5A5 → hi_rdata updates and done pulses in cycle 1. A MULT issued in the done cycle of a DIV is accepted with no bubble.
- **Reset:** resetn deasserted mid-DIV → immediate IDLE, HI=LO=0, done=0, req_ready=1; a repeat with MDU_ITER_MUL_EN defined checks the MULT done latency equals 34.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state type and latency constants for mdu_unit.
// Optional feature macro: MDU_ITER_MUL_EN (iterative shift-add multiplier).
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Constants below assume the default WIDTH of 32.
    localparam int DEFAULT_WIDTH = 32;
    localparam int DIV_CYCLES    = DEFAULT_WIDTH;
    localparam int LAT_MTX       = 1;                 // MTHI/MTLO: done in cycle 1
    localparam int LAT_DIV       = DIV_CYCLES + 2;    // done in cycle WIDTH+2
`ifdef MDU_ITER_MUL_EN
    localparam int LAT_MUL       = DIV_CYCLES + 2;
`else
    localparam int LAT_MUL       = 2;
`endif

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: request handshake, flush, status and HI/LO read bus of the MDU.
interface mdu_unit_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_rdata;
    logic [WIDTH-1:0] lo_rdata;

    // Execute stage side
    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, busy, done, hi_rdata, lo_rdata
    );

    // MDU side
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, busy, done, hi_rdata, lo_rdata
    );
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider datapath on magnitudes (partial remainder,
// quotient shift register, iteration counter). With MDU_ITER_MUL_EN the same
// registers run a radix-2 shift-add multiply: rem_q is the upper accumulator,
// quo_q the multiplier / low product shift register.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,      // start: a_i -> quo_q, b_i -> opnd_q
    input  logic             step_i,      // perform one iteration
`ifdef MDU_ITER_MUL_EN
    input  logic             mul_mode_i,  // iteration is shift-add instead of divide
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o       // current step is the final one
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd_q};

`ifdef MDU_ITER_MUL_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`endif

    assign hi_o   = rem_q;
    assign lo_o   = quo_q;
    assign last_o = (cnt_q == CW'(WIDTH - 1));

    // Next-state for one restoring-divide (or shift-add) iteration
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = a_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
`ifdef MDU_ITER_MUL_EN
            if (mul_mode_i) begin
                rem_d = sum[WIDTH:1];
                quo_d = {sum[0], quo_q[WIDTH-1:1]};
            end else
`endif
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            if (load_i) begin
                opnd_q <= b_i;
            end
        end
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit with HI/LO registers, valid/ready request
// handshake and flush. Build option MDU_ITER_MUL_EN selects an iterative
// multiplier in place of the single-cycle combinational one.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_unit_if.slave  bus
);
    mdu_state_e       state_q, state_d;
    logic [2:0]       op_q;
    logic             qneg_q, rneg_q;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic             accept;
    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_last;

    assign accept = bus.req_valid && (state_q == ST_IDLE) && !bus.flush;
    assign s1_neg = is_signed_op(bus.req_op) && bus.req_src1[WIDTH-1];
    assign s2_neg = is_signed_op(bus.req_op) && bus.req_src2[WIDTH-1];
    assign a_mag  = s1_neg ? (~bus.req_src1 + 1'b1) : bus.req_src1;
    assign b_mag  = s2_neg ? (~bus.req_src2 + 1'b1) : bus.req_src2;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi_rdata  = hi_q;
    assign bus.lo_rdata  = lo_q;

    mdu_div_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (accept && (is_mul(bus.req_op) || is_div(bus.req_op))),
`ifdef MDU_ITER_MUL_EN
        .step_i     ((state_q == ST_DIV) || (state_q == ST_MUL)),
        .mul_mode_i (state_q == ST_MUL),
`else
        .step_i     (state_q == ST_DIV),
`endif
        .a_i        (a_mag),
        .b_i        (b_mag),
        .hi_o       (core_hi),
        .lo_o       (core_lo),
        .last_o     (core_last)
    );

`ifdef MDU_ITER_MUL_EN
    logic [2*WIDTH-1:0] prod_res;
    assign prod_res = qneg_q ? (~{core_hi, core_lo} + 1'b1) : {core_hi, core_lo};
`else
    // Operands kept for the single-cycle multiply, widened by one bit so one
    // signed multiply serves both MULT and MULTU.
    logic [WIDTH-1:0]   src1_q, src2_q;
    logic [WIDTH:0]     ext1, ext2;
    logic [2*WIDTH-1:0] prod_res;
    assign ext1     = {is_signed_op(op_q) && src1_q[WIDTH-1], src1_q};
    assign ext2     = {is_signed_op(op_q) && src2_q[WIDTH-1], src2_q};
    assign prod_res = $signed({{(WIDTH-1){ext1[WIDTH]}}, ext1})
                    * $signed({{(WIDTH-1){ext2[WIDTH]}}, ext2});
`endif

    // FSM next state and HI/LO/done write decisions; flush overrides everything
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        OP_MULT, OP_MULTU: state_d = ST_MUL;
                        OP_DIV,  OP_DIVU:  state_d = ST_DIV;
                        OP_MTHI: begin hi_d = bus.req_src1; done_d = 1'b1; end
                        OP_MTLO: begin lo_d = bus.req_src1; done_d = 1'b1; end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
`ifdef MDU_ITER_MUL_EN
                if (core_last) state_d = ST_FIX;
`else
                hi_d    = prod_res[2*WIDTH-1:WIDTH];
                lo_d    = prod_res[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = ST_IDLE;
`endif
            end
            ST_DIV: begin
                if (core_last) state_d = ST_FIX;
            end
            ST_FIX: begin
`ifdef MDU_ITER_MUL_EN
                if (is_mul(op_q)) begin
                    hi_d = prod_res[2*WIDTH-1:WIDTH];
                    lo_d = prod_res[WIDTH-1:0];
                end else
`endif
                begin
                    lo_d = qneg_q ? (~core_lo + 1'b1) : core_lo;
                    hi_d = rneg_q ? (~core_hi + 1'b1) : core_hi;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State, HI/LO, done and request bookkeeping registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifndef MDU_ITER_MUL_EN
            src1_q  <= '0;
            src2_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (accept) begin
                op_q   <= bus.req_op;
                qneg_q <= s1_neg ^ s2_neg;
                rneg_q <= s1_neg;
`ifndef MDU_ITER_MUL_EN
                src1_q <= bus.req_src1;
                src2_q <= bus.req_src2;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed bench for mdu_unit at WIDTH=32. Multiply latency
// expectation follows MDU_ITER_MUL_EN through mdu_pkg::LAT_MUL.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;
    logic saw_done;

    mdu_unit_if #(.WIDTH(32)) bus ();

    mdu_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
    endtask

    // Accept edge then wait (bounded) for done; cyc = cycle index of done.
    task automatic run(output int c);
        tick();
        bus.req_valid = 1'b0;
        c = 1;
        while (bus.done !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.flush     = 1'b0;
        tick();
        tick();
        chk("rst_hi",    {32'h0, bus.hi_rdata}, 64'h0);
        chk("rst_lo",    {32'h0, bus.lo_rdata}, 64'h0);
        chk("rst_done",  {63'h0, bus.done}, 64'h0);
        chk("rst_busy",  {63'h0, bus.busy}, 64'h0);
        chk("rst_ready", {63'h0, bus.req_ready}, 64'h1);
        resetn = 1'b1;
        tick();

        // MTHI: visible with done in cycle 1, done clears next cycle
        start_req(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
        run(cyc);
        chk("mthi_lat", 64'(cyc), 64'(LAT_MTX));
        chk("mthi_hi",  {32'h0, bus.hi_rdata}, 64'hA5A5_A5A5);
        chk("mthi_lo",  {32'h0, bus.lo_rdata}, 64'h0);
        tick();
        chk("mthi_done_clr", {63'h0, bus.done}, 64'h0);
        $display("MTHI 0xA5A5A5A5 done_cycle=%0d hi=%h", cyc, bus.hi_rdata);

        // MULT / MULTU on -2 * 3
        start_req(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run(cyc);
        chk("mult_lat", 64'(cyc), 64'(LAT_MUL));
        chk("mult_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFA);
        $display("MULT -2*3 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);
        start_req(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        run(cyc);
        chk("multu_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0002_FFFF_FFFA);
        $display("MULTU 0xFFFFFFFE*3 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);

        // DIV -7/2 and DIVU 7/2
        start_req(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run(cyc);
        chk("div_lat", 64'(cyc), 64'(LAT_DIV));
        chk("div_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFD);
        $display("DIV -7/2 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);
        start_req(OP_DIVU, 32'd7, 32'd2);
        run(cyc);
        chk("divu_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0001_0000_0003);
        $display("DIVU 7/2 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);

        // Divide corners: most-negative / -1 and divide by zero
        start_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run(cyc);
        chk("div_ovf_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0000_8000_0000);
        $display("DIV 0x80000000/-1 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);
        start_req(OP_DIVU, 32'd5, 32'd0);
        run(cyc);
        chk("divu_z_lat", 64'(cyc), 64'(LAT_DIV));
        chk("divu_z_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0005_FFFF_FFFF);
        $display("DIVU 5/0 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);
        start_req(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run(cyc);
        chk("div_negz_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFB_0000_0001);
        $display("DIV -5/0 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);
        start_req(OP_DIV, 32'd5, 32'd0);
        run(cyc);
        chk("div_posz_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0005_FFFF_FFFF);
        $display("DIV 5/0 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);

        // Flush at cycle 10 of DIV 100/7 with HI=LO=0x1234
        start_req(OP_MTHI, 32'h1234, 32'h0);
        run(cyc);
        start_req(OP_MTLO, 32'h1234, 32'h0);
        run(cyc);
        start_req(OP_DIV, 32'd100, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("flush_busy_before", {63'h0, bus.busy}, 64'h1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle", {63'h0, bus.busy}, 64'h0);
        chk("flush_ready", {63'h0, bus.req_ready}, 64'h1);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            saw_done = saw_done | bus.done;
            tick();
        end
        chk("flush_no_done", {63'h0, saw_done}, 64'h0);
        chk("flush_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_1234_0000_1234);
        $display("FLUSH DIV 100/7 at cycle 10 hi=%h lo=%h", bus.hi_rdata, bus.lo_rdata);

        // Flush together with req_valid in IDLE blocks acceptance
        start_req(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        bus.flush = 1'b1;
        tick();
        chk("flush_blk_done", {63'h0, bus.done}, 64'h0);
        chk("flush_blk_hi", {32'h0, bus.hi_rdata}, 64'h1234);
        start_req(OP_DIV, 32'd9, 32'd3);
        tick();
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_blk_busy", {63'h0, bus.busy}, 64'h0);
        $display("FLUSH with req_valid: hi=%h busy=%0d", bus.hi_rdata, bus.busy);

        // Back-to-back: MULT issued in the done cycle of DIV 100/7
        start_req(OP_DIV, 32'd100, 32'd7);
        run(cyc);
        chk("b2b_div_lat", 64'(cyc), 64'(LAT_DIV));
        chk("b2b_div_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'h0000_0002_0000_000E);
        chk("b2b_ready", {63'h0, bus.req_ready}, 64'h1);
        start_req(OP_MULT, 32'd5, 32'hFFFF_FFFD);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_accepted", {63'h0, bus.busy}, 64'h1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("b2b_mul_lat", 64'(cyc), 64'(LAT_MUL));
        chk("b2b_mul_hilo", {bus.hi_rdata, bus.lo_rdata}, 64'hFFFF_FFFF_FFFF_FFF1);
        $display("B2B DIV 100/7 then MULT 5*-3 done_cycle=%0d hi=%h lo=%h", cyc, bus.hi_rdata, bus.lo_rdata);

        // Asynchronous reset in the middle of a divide
        start_req(OP_DIV, 32'd100, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy",  {63'h0, bus.busy}, 64'h0);
        chk("arst_ready", {63'h0, bus.req_ready}, 64'h1);
        chk("arst_hilo",  {bus.hi_rdata, bus.lo_rdata}, 64'h0);
        chk("arst_done",  {63'h0, bus.done}, 64'h0);
        tick();
        resetn = 1'b1;
        tick();
        start_req(OP_MTLO, 32'h0000_5A5A, 32'h0);
        run(cyc);
        chk("post_rst_lo", {32'h0, bus.lo_rdata}, 64'h5A5A);
        $display("RESET mid-DIV then MTLO lo=%h", bus.lo_rdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
